// File: rtl/key_period_pkg.sv
// Shared definitions for the key-driven period selector: debounce state encoding,
// debounce length derivation and the elaboration-time range check.
package key_period_pkg;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_DOWN,
        DB_REL_WAIT
    } db_state_e;

    localparam int DEFAULT_PW = 29;

    function automatic int db_cycles(input longint clk_hz, input longint debounce_ms);
        return int'(clk_hz / 1000 * debounce_ms);
    endfunction

    // Largest period must fit in PW bits and the index must fit in 4 bits.
    function automatic bit period_range_ok(input longint base, input longint step,
                                           input int num_steps, input int pw);
        return (num_steps >= 2) && (num_steps <= 16) &&
               ((base + longint'(num_steps - 1) * step) < (longint'(1) << pw));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, press/release debounce FSM, single-cycle
// press pulse when a press has been stable for DB_CYC cycles.
module key_debounce
    import key_period_pkg::*;
#(
    parameter int DB_CYC = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int              CW      = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYC - 1);

    logic [1:0]    sync;
    logic          key_s;
    db_state_e     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    assign key_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            state <= DB_IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], key_n};
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press    = 1'b0;
        case (state)
            DB_IDLE: begin
                if (!key_s) begin
                    state_nx = DB_PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (key_s) begin
                    state_nx = DB_IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nx = DB_DOWN;
                    press    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DB_DOWN: begin
                if (key_s) begin
                    state_nx = DB_REL_WAIT;
                    cnt_nx   = '0;
                end
            end
            DB_REL_WAIT: begin
                // Release must also be stable, so a held key never re-triggers.
                if (!key_s) begin
                    state_nx = DB_DOWN;
                end else if (cnt == CNT_MAX) begin
                    state_nx = DB_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = DB_IDLE;
        endcase
    end

endmodule

// File: rtl/key_period_sel.sv
// Up/down keys step a period index; the selected blink period is offered to the
// blinker over valid/ready, holding data stable until accepted.
module key_period_sel
    import key_period_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int NUM_STEPS   = 9,
    parameter int BASE_PERIOD = 100_000_000,
    parameter int STEP_PERIOD = 50_000_000,
    parameter int PW          = DEFAULT_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_up_n,
    input  logic          key_dn_n,
    output logic [PW-1:0] period,
    output logic [3:0]    step_idx,
    output logic          period_vld,
    input  logic          period_rdy
);

    localparam int            DB_CYC   = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam logic [3:0]    LAST_IDX = 4'(NUM_STEPS - 1);
    localparam logic [PW-1:0] BASE_W   = PW'(BASE_PERIOD);
    localparam logic [PW-1:0] STEP_W   = PW'(STEP_PERIOD);

    generate
        if (!period_range_ok(BASE_PERIOD, STEP_PERIOD, NUM_STEPS, PW)) begin : g_bad_cfg
            $error("key_period_sel: NUM_STEPS outside 2..16 or largest period exceeds PW bits");
        end
    endgenerate

    logic       up_p, dn_p;
    logic [3:0] sel_idx;
    logic       out_free;

    key_debounce #(.DB_CYC(DB_CYC)) u_up (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_up_n),
        .press (up_p)
    );

    key_debounce #(.DB_CYC(DB_CYC)) u_dn (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_dn_n),
        .press (dn_p)
    );

    // Working index moves freely; only the output register waits for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_idx <= 4'd0;
        end else if (up_p && !dn_p) begin
            sel_idx <= (sel_idx == LAST_IDX) ? 4'd0 : sel_idx + 4'd1;
        end else if (dn_p && !up_p) begin
            sel_idx <= (sel_idx == 4'd0) ? LAST_IDX : sel_idx - 4'd1;
        end
    end

    assign out_free = !period_vld || period_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period     <= BASE_W;
            step_idx   <= 4'd0;
            period_vld <= 1'b0;
        end else if (out_free) begin
            if (sel_idx != step_idx) begin
                step_idx   <= sel_idx;
                period     <= BASE_W + PW'(sel_idx) * STEP_W;
                period_vld <= 1'b1;
            end else begin
                period_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_period_sel.sv
// Scoreboard bench for key_period_sel: stimulus pushes expected transfers, a
// negedge monitor pops and compares on every accepted handshake.
module tb_key_period_sel;

    localparam int DB_CYC = 5;
    localparam int N      = 9;
    localparam int BASE   = 100;
    localparam int STEP   = 50;
    localparam int PW     = 29;
    // raw key edge -> period_vld: 2 sync, enter wait, DB_CYC-1 count, pulse edge, output reg
    localparam int LAT    = DB_CYC + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_up_n = 1'b1;
    logic          key_dn_n = 1'b1;
    logic          period_rdy = 1'b1;
    logic [PW-1:0] period;
    logic [3:0]    step_idx;
    logic          period_vld;

    int checks   = 0;
    int failures = 0;
    int model_idx = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        int idx;
        int per;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    key_period_sel #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (5),
        .NUM_STEPS   (N),
        .BASE_PERIOD (BASE),
        .STEP_PERIOD (STEP),
        .PW          (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_up_n   (key_up_n),
        .key_dn_n   (key_dn_n),
        .period     (period),
        .step_idx   (step_idx),
        .period_vld (period_vld),
        .period_rdy (period_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_period(input int i);
        return BASE + i * STEP;
    endfunction

    task automatic model_step(input bit up);
        model_idx = up ? (model_idx + 1) % N : (model_idx + N - 1) % N;
    endtask

    task automatic expect_xfer(input int i);
        sb.push_back('{i, exp_period(i)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the selected keys low for len cycles, then release and let the FSMs settle.
    task automatic key_pulse(input bit up, input bit dn, input int len);
        if (up) key_up_n = 1'b0;
        if (dn) key_dn_n = 1'b0;
        tick(len);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        tick(DB_CYC + 4);
    endtask

    task automatic press(input bit up, input int len);
        model_step(up);
        expect_xfer(model_idx);
        key_pulse(up, !up, len);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((period_vld || sb.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        check({name, "_timeout"}, 64'(n >= 300), 0);
        check({name, "_idx"}, 64'(step_idx), 64'(model_idx));
    endtask

    always @(negedge clk) begin
        if (!rst && period_vld && period_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL xfer_unexpected actual=idx%0d/%0d expected=no transfer",
                         step_idx, period);
            end else begin
                mon_e = sb.pop_front();
                check("xfer_idx", 64'(step_idx), 64'(mon_e.idx));
                check("xfer_period", 64'(period), 64'(mon_e.per));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            period_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int first_hi;
        int hi_cnt;

        tick(3);
        check("rst_period", 64'(period), BASE);
        check("rst_idx", 64'(step_idx), 0);
        check("rst_vld", 64'(period_vld), 0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("idle_vld", 64'(period_vld), 0);
        end
        check("idle_period", 64'(period), BASE);

        // single held press: measure latency and width of period_vld
        model_step(1'b1);
        expect_xfer(model_idx);
        key_up_n = 1'b0;
        first_hi = -1;
        hi_cnt   = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            @(negedge clk);
            if (period_vld) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = k;
            end
            @(posedge clk);
            #1;
            if (k == 9) key_up_n = 1'b1;
        end
        check("press_latency", 64'(first_hi), LAT);
        check("press_vld_width", 64'(hi_cnt), 1);
        check("press_period", 64'(period), 150);
        check("press_idx", 64'(step_idx), 1);
        tick(DB_CYC + 4);
        wait_idle("press1");

        // bounce shorter than the debounce window
        key_up_n = 1'b0; tick(3);
        key_up_n = 1'b1; tick(1);
        key_up_n = 1'b0; tick(3);
        key_up_n = 1'b1; tick(DB_CYC + 4);
        check("bounce_vld", 64'(period_vld), 0);
        check("bounce_idx", 64'(step_idx), 1);
        press(1'b1, 8);
        wait_idle("after_bounce");
        check("after_bounce_period", 64'(period), 200);

        // wrap both ways
        press(1'b0, 8);
        press(1'b0, 8);
        wait_idle("down_to0");
        press(1'b0, 8);
        wait_idle("wrap_down");
        check("wrap_down_idx", 64'(step_idx), 8);
        check("wrap_down_period", 64'(period), 500);
        press(1'b1, 8);
        wait_idle("wrap_up");
        check("wrap_up_idx", 64'(step_idx), 0);
        check("wrap_up_period", 64'(period), 100);

        // consumer stalled: data held, latest index wins on back-to-back transfer
        period_rdy = 1'b0;
        model_step(1'b1); expect_xfer(model_idx); key_pulse(1'b1, 1'b0, 8);
        model_step(1'b1); key_pulse(1'b1, 1'b0, 8);
        model_step(1'b1); key_pulse(1'b1, 1'b0, 8);
        check("hold_vld", 64'(period_vld), 1);
        check("hold_period", 64'(period), 150);
        check("hold_idx", 64'(step_idx), 1);
        expect_xfer(model_idx);
        period_rdy = 1'b1; tick(1); period_rdy = 1'b0;
        @(negedge clk);
        check("b2b_vld", 64'(period_vld), 1);
        check("b2b_period", 64'(period), 250);
        check("b2b_idx", 64'(step_idx), 3);
        @(posedge clk); #1;
        period_rdy = 1'b1; tick(1); period_rdy = 1'b0;
        @(negedge clk);
        check("b2b_drop", 64'(period_vld), 0);
        @(posedge clk); #1;

        // presses returning to the pending index leave the transfer alone
        model_step(1'b1); expect_xfer(model_idx); key_pulse(1'b1, 1'b0, 8);
        model_step(1'b1); key_pulse(1'b1, 1'b0, 8);
        model_step(1'b0); key_pulse(1'b0, 1'b1, 8);
        check("same_vld", 64'(period_vld), 1);
        check("same_period", 64'(period), 300);
        period_rdy = 1'b1;
        wait_idle("same_accept");
        tick(5);
        check("same_no_more", 64'(period_vld), 0);

        // simultaneous presses cancel
        key_pulse(1'b1, 1'b1, 8);
        check("both_vld", 64'(period_vld), 0);
        check("both_idx", 64'(step_idx), 4);

        // reset while up key is in its press window
        key_up_n = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("rst2_period", 64'(period), BASE);
        check("rst2_idx", 64'(step_idx), 0);
        check("rst2_vld", 64'(period_vld), 0);
        rst = 1'b0;
        model_idx = 0;
        sb.delete();
        model_step(1'b1);
        expect_xfer(model_idx);
        for (int k = 0; k < LAT - 1; k++) begin
            tick(1);
            check("rst2_nopulse", 64'(period_vld), 0);
        end
        tick(6);
        key_up_n = 1'b1;
        tick(DB_CYC + 4);
        wait_idle("rst2_press");

        // randomized presses, bounces and cancelling pairs against a random consumer
        rand_rdy = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int kind;
            bit u;
            kind = int'($urandom_range(0, 3));
            u    = 1'($urandom_range(0, 1));
            case (kind)
                0, 1: press(kind == 0, int'($urandom_range(DB_CYC + 1, DB_CYC + 6)));
                2:    key_pulse(u, !u, int'($urandom_range(1, DB_CYC)));
                default: key_pulse(1'b1, 1'b1, int'($urandom_range(DB_CYC + 1, DB_CYC + 6)));
            endcase
            wait_idle("rand");
            check("rand_period", 64'(period), 64'(exp_period(model_idx)));
        end
        rand_rdy = 1'b0;
        tick(1);
        period_rdy = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_period_sel.md
Name: key_period_sel

Overview:
- Upstream control stage for the LED blinker.
- Debounces two active-low push buttons (up/down) and steps an index through NUM_STEPS period settings.
- Presents the selected blink period to the blinker over a valid/ready handshake.
- The blinker loads a new period only at its own cycle boundary (asserts period_rdy then).

Parameters:
- CLK_HZ, 50_000_000, clock frequency in Hz
- DEBOUNCE_MS, 20, stable time required on a key edge
- NUM_STEPS, 9, number of period settings (2..16)
- BASE_PERIOD, 100_000_000, period at index 0, in clk cycles
- STEP_PERIOD, 50_000_000, period increment per index
- PW, 29, period width in bits

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- key_up_n  in  1  raw up button, active-low, asynchronous
- key_dn_n  in  1  raw down button, active-low, asynchronous
- period  out  PW  selected period = BASE_PERIOD + step_idx*STEP_PERIOD
- step_idx  out  4  index of the presented period
- period_vld  out  1  period/step_idx hold an unaccepted update
- period_rdy  in  1  consumer accepts when high with period_vld

Behaviour:
- Reset values: period=BASE_PERIOD, step_idx=0, period_vld=0. All debounce FSMs go to IDLE, counters to 0, synchronizers to 1.
- Reset mid-operation aborts any debounce or pending update. No transfer is issued after reset; the consumer's reset default equals BASE_PERIOD.
- Each key passes a 2-flop synchronizer before debouncing.
- DB_CYC = CLK_HZ/1000*DEBOUNCE_MS (1_000_000 at defaults). Debounce counter width is ceil(log2(DB_CYC)).
- Debounce FSM per key:
  - IDLE: key low -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: key high -> IDLE. Counter==DB_CYC-1 -> DOWN, with a one-cycle press pulse in the same cycle.
  - DOWN: key high -> REL_WAIT, counter cleared.
  - REL_WAIT: key low -> DOWN. Counter==DB_CYC-1 -> IDLE.
- Result: exactly one pulse per press. Held keys do not auto-repeat. Bounces shorter than DB_CYC are ignored.
- Working index sel_idx:
  - Up pulse: sel_idx+1, wrapping NUM_STEPS-1 -> 0.
  - Down pulse: sel_idx-1, wrapping 0 -> NUM_STEPS-1.
  - Up and down pulses in the same cycle: no change.
- Output register (period, step_idx) updates only when not (period_vld && !period_rdy). Data is stable while valid is high and unaccepted.
- When sel_idx != step_idx and the output may update:
  - Load step_idx<=sel_idx and period<=BASE_PERIOD+sel_idx*STEP_PERIOD on the next edge.
  - Set period_vld=1.
  - Latency from press pulse to period_vld is 2 cycles (index register, output register).
- Handshake fires on a cycle with period_vld && period_rdy:
  - If sel_idx==step_idx, period_vld drops next cycle.
  - Otherwise the newer value loads and period_vld stays high (back-to-back transfer).
- Presses while a transfer is pending only move sel_idx; latest wins. Presses that return sel_idx to step_idx before acceptance leave the pending transfer unchanged.
- Arithmetic:
  - Product sel_idx*STEP_PERIOD is computed at PW bits.
  - Elaboration check: BASE_PERIOD+(NUM_STEPS-1)*STEP_PERIOD < 2**PW (500_000_000 < 536_870_912 at defaults).
  - Elaboration check: NUM_STEPS <= 16.
- period_rdy high without period_vld has no effect.

Decomposition:
- Package key_period_pkg holds:
  - Debounce state encoding (IDLE, PRESS_WAIT, DOWN, REL_WAIT).
  - DB_CYC derivation function.
  - Default PW.
  - Elaboration range-check function.
- Sub-module key_debounce (synchronizer + FSM + counter, press pulse output) is instantiated twice. Top holds index, output register and handshake.

Test Plan (CLK_HZ=1000, DEBOUNCE_MS=5 -> DB_CYC=5; BASE 100, STEP 50):
- Reset release, no keys -> period=100, step_idx=0, period_vld=0 indefinitely.
- Up held 10 cycles, period_rdy=1 -> one pulse; period_vld high exactly 1 cycle, 2 cycles after the pulse; period=150, step_idx=1.
- Up low 3 cycles, high, low 3 cycles (bounce) -> no pulse, no change. Release then press held 8 cycles -> single step.
- Down press from index 0 -> step_idx=8, period=500. Then up press -> step_idx=0, period=100 (both wraps).
- period_rdy=0, three up presses from 0 -> vld high, period stays 150 / idx 1 until rdy. Rdy pulse -> next cycle period=250 / idx 3, vld still high. Second rdy -> vld low.
- Simultaneous up/down pulses -> no change. Then rst asserted mid-PRESS_WAIT -> outputs return to reset values; key still held after release produces no pulse until DB_CYC elapses.
